// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment digit scanner.
// Holds the scan FSM state encoding and the default blank digit code.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam logic [4:0] BLANK_CODE_DEFAULT = 5'h1F;

endpackage

// File: rtl/digit_scan_mux_scan_timer.sv
// Modulo-N up counter with synchronous clear and a terminal-count pulse.
// tc is high for the single enabled cycle in which the count wraps N-1 -> 0.
module scan_timer #(
  parameter int N = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner: guard gap then show slot per digit, frame-wide
// shadow capture, leading-zero suppression and per-digit blinking.
module digit_scan_mux
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 5,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 8,
  parameter int BLINK_FRAMES = 32,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = DIGIT_W'(BLANK_CODE_DEFAULT),
  parameter int LZ_DIGITS    = NUM_DIGITS - 1,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          lz_en,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [IW-1:0]                 digit_sel,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          frame_tick,
  output scan_state_e                   state_dbg
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_e state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic frame_start, frame_end, frame_pend;
  logic guard_tc, show_tc, blink_tc;
  logic blink_on;

  logic [NUM_DIGITS*DIGIT_W-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]         sh_blink;
  logic                          sh_lz;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  prefix_zero;
  logic [DIGIT_W-1:0]    cur_code;
  logic                  blank_now;

  logic [NUM_DIGITS-1:0] anode_d;
  logic [DIGIT_W-1:0]    code_d;
  logic [IW-1:0]         sel_d;
  logic                  tick_d;

  assign state_dbg = state;

  scan_timer #(.N(GUARD_CYCLES)) u_guard_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable || state != GUARD),
    .en      (state == GUARD),
    .tc      (guard_tc)
  );

  scan_timer #(.N(SHOW_CYCLES)) u_show_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable || state != SHOW),
    .en      (state == SHOW),
    .tc      (show_tc)
  );

  // Counts completed frames, so the first frame after enable is never skipped.
  scan_timer #(.N(BLINK_FRAMES)) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable),
    .en      (frame_end),
    .tc      (blink_tc)
  );

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = GUARD;
          idx_nxt     = '0;
          frame_start = 1'b1;
        end
      end
      GUARD: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (guard_tc) begin
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (show_tc) begin
          state_nxt = GUARD;
          if (idx == LAST_IDX) begin
            idx_nxt     = '0;
            frame_start = 1'b1;
            frame_end   = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      frame_pend <= 1'b0;
      blink_on   <= 1'b1;
      sh_digits  <= '0;
      sh_blink   <= '0;
      sh_lz      <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      frame_pend <= frame_start;
      if (!enable) begin
        blink_on <= 1'b1;
      end else if (blink_tc) begin
        blink_on <= ~blink_on;
      end
      // Inputs are sampled once per frame so a digit update never tears a frame.
      if (frame_start) begin
        sh_digits <= digits_in;
        sh_blink  <= blink_mask;
        sh_lz     <= lz_en;
      end
    end
  end

  // Digit i is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lz_blank    = '0;
    prefix_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      prefix_zero = prefix_zero && (sh_digits[i*DIGIT_W +: DIGIT_W] == '0);
      lz_blank[i] = sh_lz && prefix_zero && (i < LZ_DIGITS);
    end
  end

  assign cur_code  = sh_digits[idx*DIGIT_W +: DIGIT_W];
  assign blank_now = lz_blank[idx] || (sh_blink[idx] && !blink_on);

  // Pin values are derived from the current state and registered below; a low
  // enable forces the idle pattern on the very next edge.
  always_comb begin
    anode_d = '1;
    code_d  = BLANK_CODE;
    sel_d   = '0;
    tick_d  = 1'b0;
    if (enable) begin
      case (state)
        GUARD: begin
          sel_d  = idx;
          tick_d = frame_pend;
        end
        SHOW: begin
          sel_d        = idx;
          anode_d[idx] = 1'b0;
          code_d       = blank_now ? BLANK_CODE : cur_code;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode_n    <= '1;
      digit_out  <= BLANK_CODE;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      anode_n    <= anode_d;
      digit_out  <= code_d;
      digit_sel  <= sel_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomised scoreboard bench for digit_scan_mux; expected pin values come from
// an arithmetic model of frame/slot position since the last enable edge.
module tb_digit_scan_mux;
  import digit_scan_pkg::*;

  localparam int N     = 4;
  localparam int W     = 5;
  localparam int S     = 4;
  localparam int G     = 2;
  localparam int BF    = 2;
  localparam int IW    = 2;
  localparam int SLOT  = G + S;
  localparam int FRAME = SLOT * N;
  localparam int LZD   = N - 1;
  localparam int EW    = N + W + IW + 1;
  localparam logic [W-1:0] BLANK = 5'h1F;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              enable = 1'b0;
  logic [N*W-1:0]    digits_in = '0;
  logic [N-1:0]      blink_mask = '0;
  logic              lz_en = 1'b0;
  logic [W-1:0]      digit_out;
  logic [IW-1:0]     digit_sel;
  logic [N-1:0]      anode_n;
  logic              frame_tick;
  scan_state_e       state_dbg;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS   (N),
    .DIGIT_W      (W),
    .SHOW_CYCLES  (S),
    .GUARD_CYCLES (G),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .digit_out  (digit_out),
    .digit_sel  (digit_sel),
    .anode_n    (anode_n),
    .frame_tick (frame_tick),
    .state_dbg  (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int            run_len = 0;
  logic [W-1:0]  m_dig[N];
  logic [N-1:0]  m_blink = '0;
  logic          m_lz = 1'b0;

  // Pins after the edge that completes `r` consecutive enabled edges.
  function automatic logic [EW-1:0] model_pins(input int r);
    logic [N-1:0]  an;
    logic [W-1:0]  code;
    logic [IW-1:0] sel;
    logic          tk;
    logic          allz;
    int t, f, s, p;
    an = '1; code = BLANK; sel = '0; tk = 1'b0;
    if (r >= 2) begin
      t = r - 2;
      f = t / FRAME;
      s = (t % FRAME) / SLOT;
      p = t % SLOT;
      sel = IW'(s);
      if (p < G) begin
        tk = (s == 0) && (p == 0);
      end else begin
        an[s] = 1'b0;
        code  = m_dig[s];
        if (m_blink[s] && ((f / BF) % 2 == 1)) code = BLANK;
        if (m_lz && s < LZD) begin
          allz = 1'b1;
          for (int j = 0; j <= s; j++) if (m_dig[j] != '0) allz = 1'b0;
          if (allz) code = BLANK;
        end
      end
    end
    return {an, code, sel, tk};
  endfunction

  always @(posedge clk) begin
    if (!reset_n || !enable) run_len = 0;
    else run_len = run_len + 1;
    exp_q.push_back(model_pins(run_len));
    // A frame's inputs are latched as the scan restarts at digit 0.
    if (run_len >= 1 && (run_len - 1) % FRAME == 0) begin
      for (int i = 0; i < N; i++) m_dig[i] = digits_in[i*W +: W];
      m_blink = blink_mask;
      m_lz    = lz_en;
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic report(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got anode_n=%b digit_out=%h digit_sel=%0d frame_tick=%b, expected anode_n=%b digit_out=%h digit_sel=%0d frame_tick=%b",
               name, $time, got[11:8], got[7:3], got[2:1], got[0], exp[11:8], exp[7:3], exp[2:1], exp[0]);
    end
  endtask

  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
    end else begin
      checks--;
      e = exp_q.pop_front();
      report("pins", {anode_n, digit_out, digit_sel, frame_tick}, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
    digits_in = {d3, d2, d1, d0};
  endtask

  function automatic logic [W-1:0] rand_digit();
    return ($urandom_range(0, 2) == 0) ? W'(0) : W'($urandom_range(0, 31));
  endfunction

  task automatic randomize_digits();
    set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
  endtask

  // Wait until the pins display scan position `pos` within a frame.
  task automatic wait_pos(input int pos, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4 * FRAME && !ok; c++) begin
      @(negedge clk);
      if (run_len >= 2 && (run_len - 2) % FRAME == pos) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got no scan position %0d within %0d cycles, expected it", name, pos, 4 * FRAME);
    end
  endtask

  task automatic check_idle_now(input string name);
    logic [EW-1:0] idle_pins;
    idle_pins = {{N{1'b1}}, BLANK, {IW{1'b0}}, 1'b0};
    report(name, {anode_n, digit_out, digit_sel, frame_tick}, idle_pins);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    #2 reset_n = 1'b0;
    #1 check_idle_now("reset_async");
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Plain scan of four distinct digits.
    set_digits(5'd3, 5'd2, 5'd1, 5'd0);
    enable = 1'b1;
    cycles(2 * FRAME + 3);

    // Inputs change mid-frame; each frame must keep what it latched.
    for (int k = 0; k < 30; k++) begin
      cycles($urandom_range(3, 17));
      randomize_digits();
    end

    // Leading-zero suppression.
    lz_en = 1'b1;
    set_digits(5'd0, 5'd0, 5'd0, 5'd0);
    cycles(2 * FRAME);
    set_digits(5'd0, 5'd5, 5'd0, 5'd7);
    cycles(2 * FRAME);
    lz_en = 1'b0;

    // Blinking of digit 1 across several half-periods.
    set_digits(5'd9, 5'd4, 5'd6, 5'd8);
    blink_mask = 4'b0010;
    cycles(6 * FRAME);

    // Enable dropped while digit 2 is being shown.
    wait_pos(2 * SLOT + G + 1, "wait_show_idx2");
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(FRAME + 5);
    blink_mask = '0;

    // Randomised segments with random enable drops at any point of the scan.
    for (int seg = 0; seg < 12; seg++) begin
      randomize_digits();
      blink_mask = N'($urandom_range(0, 15));
      lz_en      = 1'($urandom_range(0, 1));
      enable     = 1'b1;
      for (int k = 0; k < 6; k++) begin
        cycles($urandom_range(5, 40));
        if ($urandom_range(0, 3) == 0) randomize_digits();
      end
      enable = 1'b0;
      cycles($urandom_range(1, 5));
    end

    // Asynchronous reset while a digit is lit.
    enable = 1'b1;
    set_digits(5'd1, 5'd2, 5'd3, 5'd4);
    wait_pos(SLOT + G + 1, "wait_show_idx1");
    reset_n = 1'b0;
    #1 check_idle_now("reset_mid_show");
    cycles(3);
    reset_n = 1'b1;
    cycles(FRAME + 4);

    enable = 1'b0;
    cycles(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 NUM_DIGITS, 4, number of display digits (2..8); index 0 is the most significant digit.
REQ-002 DIGIT_W, 5, width of each digit code.
REQ-003 SHOW_CYCLES, 50000, clock cycles each digit is driven (>=1).
REQ-004 GUARD_CYCLES, 8, all-anodes-off cycles before each digit (>=1); anti-ghosting gap.
REQ-005 BLINK_FRAMES, 32, full scan frames per blink half-period (>=1).
REQ-006 BLANK_CODE, 5'h1F, digit code driven when a digit is blanked.
REQ-007 LZ_DIGITS, NUM_DIGITS-1, count of most-significant digits eligible for leading-zero suppression.
REQ-008 clk  in  1  system clock; all state on rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  scan run; low blanks the display.
REQ-011 digits_in  in  NUM_DIGITS*DIGIT_W  digit codes; digit i at bits [i*DIGIT_W +: DIGIT_W].
REQ-012 blink_mask  in  NUM_DIGITS  bit i set -> digit i blinks.
REQ-013 lz_en  in  1  enables leading-zero suppression.
REQ-014 digit_out  out  DIGIT_W  code for the active digit (registered).
REQ-015 digit_sel  out  clog2(NUM_DIGITS)  index of the active digit (registered).
REQ-016 anode_n  out  NUM_DIGITS  active-low one-hot digit enable (registered).
REQ-017 frame_tick  out  1  one-cycle pulse at the start of each frame.

Function
REQ-018 The FSM SHALL have states IDLE, GUARD, SHOW; one slot = GUARD for GUARD_CYCLES, then SHOW for SHOW_CYCLES.
REQ-019 IDLE: anode_n all ones, digit_out = BLANK_CODE; leave to GUARD, index 0, when enable = 1.
REQ-020 GUARD: anode_n all ones; after GUARD_CYCLES -> SHOW, same index.
REQ-021 SHOW: anode_n bit [index] = 0, others 1; after SHOW_CYCLES -> GUARD, index+1, wrapping NUM_DIGITS-1 -> 0.
REQ-022 Entering GUARD with index 0 SHALL capture digits_in, blink_mask, lz_en into a shadow register, so a frame never tears.
REQ-023 frame_tick SHALL pulse exactly one cycle on each index-0 GUARD entry, including the first after IDLE.
REQ-024 Digit i SHALL show BLANK_CODE if blink_mask[i] = 1 and blink phase = off.
REQ-025 Digit i SHALL also show BLANK_CODE if lz_en = 1, i < LZ_DIGITS, and shadow digits 0..i are all zero.
REQ-026 Otherwise digit i SHALL show its shadow code.
REQ-027 Blink phase SHALL start on, then toggle every BLINK_FRAMES frame_ticks.
REQ-028 Outputs SHALL be registered: pins reflect state/index one cycle after the FSM changes.
REQ-029 enable falling in any state: next cycle -> IDLE; counters, index and blink phase reset; no frame_tick.
REQ-030 Simultaneous slot end and enable = 0: enable wins (-> IDLE).
REQ-031 Counters SHALL be sized for their parameter values, with no overflow at maximum count.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE, index 0, counters 0, blink phase on, shadow 0.
REQ-033 During reset: anode_n all ones, digit_out = BLANK_CODE, digit_sel = 0, frame_tick = 0.
REQ-034 Release SHALL be synchronous to clk; the first GUARD is entered no earlier than the first edge with reset_n high and enable = 1.

Structure
REQ-035 Package digit_scan_pkg SHALL hold the state enum (IDLE/GUARD/SHOW) and the BLANK_CODE default constant.
REQ-036 One sub-module, scan_timer: parametrised modulo-N counter with clear, enable and terminal-count pulse; instantiated for slot timing and blink frame counting.

Verification
REQ-037 Bench at NUM_DIGITS=4, SHOW_CYCLES=4, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Scan: reset, enable=1, digits {3,2,1,0}: anode_n cycles 1111x2, 1110x4, 1111x2, 1101x4, ...; slot period 6; frame 24; frame_tick every 24 cycles.
- Tear: change digits_in mid-frame: digit_out unchanged until after the next frame_tick.
- Leading zeros: lz_en=1, digits idx0..3 = {0,0,0,0}: idx0..2 = 5'h1F, idx3 = 0; with {0,5,0,7}: only idx0 blanked.
- Blink: blink_mask=4'b0010: idx1 shows code for 2 frames, then 5'h1F for 2 frames, repeating; others steady.
- Enable drop: enable=0 mid-SHOW idx2: next cycle IDLE, anode_n=1111; on re-enable, GUARD idx0 with frame_tick.
- Reset mid-SHOW: reset_n low -> anode_n=1111 and digit_out=5'h1F immediately, without a clk edge.
